throw_charge: RTL and testbench

//  Parametrised throw-power charger for the cat/dog artillery game. Runs off the 60 MHz domain.

---
 rtl/variable_pkg.sv | 31 +++
 rtl/tick_divider.sv | 37 +++
 rtl/throw_charge.sv | 183 ++++++++++++++++++
 tb/tb_throw_charge.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/variable_pkg.sv
//------------------------------------------------------------------------------
// variable_pkg : shared game constants, player ids, ramp modes and charger states
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package variable_pkg;

    localparam logic [1:0] PLAYER_1 = 2'd1;
    localparam logic [1:0] PLAYER_2 = 2'd2;

    typedef enum logic [1:0] {
        RAMP_SAT      = 2'd0,
        RAMP_PINGPONG = 2'd1,
        RAMP_WRAP     = 2'd2
    } ramp_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHARGE = 2'd1,
        ST_FIRE   = 2'd2
    } charge_state_t;

    function automatic logic is_my_turn(input logic turn, input logic [1:0] player);
        return ((turn == 1'b0) && (player == PLAYER_1)) ||
               ((turn == 1'b1) && (player == PLAYER_2));
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_divider.sv
//------------------------------------------------------------------------------
// tick_divider : free-running modulo-DIV counter; tick_o flags the last count
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    // tick_o depends only on the count so the caller can gate it with its own enable
    assign tick_o = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/throw_charge.sv
//------------------------------------------------------------------------------
// throw_charge : throw-power charger; ramps power while left is held, fires on release
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module throw_charge
    import variable_pkg::*;
#(
    parameter int         POWER_W            = 5,
    parameter int         TICK_DIV           = 2_820_000,
    parameter ramp_mode_t RAMP_MODE          = RAMP_SAT,
    parameter int         MIN_CHARGE_TICKS   = 1,
    parameter int         AUTO_RELEASE_TICKS = 0
) (
    input  logic               clk60MHz,
    input  logic               rst_n,
    input  logic               left,
    input  logic               right,
    input  logic               turn,
    input  logic [1:0]         current_player,
    input  logic               end_throw,
    output logic [POWER_W-1:0] power,
    output logic               throw_flag,
    output logic               charging
);

    localparam int TW = $clog2(AUTO_RELEASE_TICKS + MIN_CHARGE_TICKS + 2);
    localparam logic [POWER_W-1:0] POWER_MAX = '1;
    localparam logic [TW-1:0]      TICKS_MAX = '1;
    localparam logic [TW-1:0]      MIN_T     = TW'(MIN_CHARGE_TICKS);
    localparam logic [TW-1:0]      AUTO_T    = TW'(AUTO_RELEASE_TICKS);

    charge_state_t      state_q, state_d;
    logic [POWER_W-1:0] power_q, power_d;
    logic [TW-1:0]      ticks_q, ticks_d;
    logic               dir_q, dir_d;
    logic               throw_flag_q, throw_flag_d;
    logic               charging_q, charging_d;

    logic               w_my_turn;
    logic               w_auto_fire;
    logic               w_div_en;
    logic               w_div_clr;
    logic               w_tick;
    logic [POWER_W-1:0] w_step_power;
    logic               w_step_dir;

    assign w_my_turn   = is_my_turn(turn, current_player);
    assign w_auto_fire = (AUTO_RELEASE_TICKS != 0) && (ticks_q == AUTO_T);
    // The divider only advances on cycles that stay in CHARGE
    assign w_div_en    = (state_q == ST_CHARGE) && left && !right && !w_auto_fire;
    assign w_div_clr   = (state_q != ST_CHARGE);

    tick_divider #(
        .DIV (TICK_DIV)
    ) u_tick_divider (
        .clk    (clk60MHz),
        .rst_n  (rst_n),
        .en_i   (w_div_en),
        .clr_i  (w_div_clr),
        .tick_o (w_tick)
    );

    // dir_q: 0 = ramping up, 1 = ramping down (ping-pong only)
    always_comb begin
        w_step_power = power_q;
        w_step_dir   = dir_q;
        case (RAMP_MODE)
            RAMP_WRAP: begin
                w_step_power = power_q + 1'b1;
            end
            RAMP_PINGPONG: begin
                if (!dir_q) begin
                    if (power_q == POWER_MAX) begin
                        w_step_dir   = 1'b1;
                        w_step_power = power_q - 1'b1;
                    end else begin
                        w_step_power = power_q + 1'b1;
                    end
                end else begin
                    if (power_q == '0) begin
                        w_step_dir   = 1'b0;
                        w_step_power = power_q + 1'b1;
                    end else begin
                        w_step_power = power_q - 1'b1;
                    end
                end
            end
            default: begin
                if (power_q != POWER_MAX) begin
                    w_step_power = power_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        power_d      = power_q;
        ticks_d      = ticks_q;
        dir_d        = dir_q;
        throw_flag_d = throw_flag_q;
        charging_d   = charging_q;
        case (state_q)
            ST_IDLE: begin
                throw_flag_d = 1'b0;
                charging_d   = 1'b0;
                if (left && w_my_turn && !right) begin
                    state_d    = ST_CHARGE;
                    power_d    = '0;
                    ticks_d    = '0;
                    dir_d      = 1'b0;
                    charging_d = 1'b1;
                end
            end
            ST_CHARGE: begin
                if (right) begin
                    state_d    = ST_IDLE;
                    power_d    = '0;
                    charging_d = 1'b0;
                end else if (!left) begin
                    charging_d = 1'b0;
                    if ((MIN_CHARGE_TICKS != 0) && (ticks_q < MIN_T)) begin
                        state_d = ST_IDLE;
                        power_d = '0;
                    end else begin
                        state_d      = ST_FIRE;
                        throw_flag_d = 1'b1;
                    end
                end else if (w_auto_fire) begin
                    state_d      = ST_FIRE;
                    charging_d   = 1'b0;
                    throw_flag_d = 1'b1;
                end else if (w_tick) begin
                    if (ticks_q != TICKS_MAX) begin
                        ticks_d = ticks_q + 1'b1;
                    end
                    power_d = w_step_power;
                    dir_d   = w_step_dir;
                end
            end
            ST_FIRE: begin
                throw_flag_d = 1'b1;
                charging_d   = 1'b0;
                if (end_throw) begin
                    state_d      = ST_IDLE;
                    throw_flag_d = 1'b0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                throw_flag_d = 1'b0;
                charging_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            power_q      <= '0;
            ticks_q      <= '0;
            dir_q        <= 1'b0;
            throw_flag_q <= 1'b0;
            charging_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            power_q      <= power_d;
            ticks_q      <= ticks_d;
            dir_q        <= dir_d;
            throw_flag_q <= throw_flag_d;
            charging_q   <= charging_d;
        end
    end

    assign power      = power_q;
    assign throw_flag = throw_flag_q;
    assign charging   = charging_q;

endmodule

`default_nettype wire

// File: tb/tb_throw_charge.sv
//------------------------------------------------------------------------------
// tb_throw_charge : directed checks of throw_charge in SAT, PINGPONG, WRAP,
//                   minimum-charge and auto-release configurations
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_throw_charge;
    import variable_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       right, turn, end_throw;
    logic [1:0] current_player;
    logic       left_sat, left_pp, left_wr, left_min, left_auto;

    logic [4:0] pw_sat, pw_pp, pw_wr, pw_min, pw_auto;
    logic       tf_sat, tf_pp, tf_wr, tf_min, tf_auto;
    logic       ch_sat, ch_pp, ch_wr, ch_min, ch_auto;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    throw_charge #(.POWER_W(5), .TICK_DIV(4), .RAMP_MODE(RAMP_SAT),
                   .MIN_CHARGE_TICKS(1), .AUTO_RELEASE_TICKS(0)) dut_sat (
        .clk60MHz(clk), .rst_n(rst_n), .left(left_sat), .right(right), .turn(turn),
        .current_player(current_player), .end_throw(end_throw),
        .power(pw_sat), .throw_flag(tf_sat), .charging(ch_sat));

    throw_charge #(.POWER_W(5), .TICK_DIV(4), .RAMP_MODE(RAMP_PINGPONG),
                   .MIN_CHARGE_TICKS(1), .AUTO_RELEASE_TICKS(0)) dut_pp (
        .clk60MHz(clk), .rst_n(rst_n), .left(left_pp), .right(right), .turn(turn),
        .current_player(current_player), .end_throw(end_throw),
        .power(pw_pp), .throw_flag(tf_pp), .charging(ch_pp));

    throw_charge #(.POWER_W(5), .TICK_DIV(4), .RAMP_MODE(RAMP_WRAP),
                   .MIN_CHARGE_TICKS(1), .AUTO_RELEASE_TICKS(0)) dut_wr (
        .clk60MHz(clk), .rst_n(rst_n), .left(left_wr), .right(right), .turn(turn),
        .current_player(current_player), .end_throw(end_throw),
        .power(pw_wr), .throw_flag(tf_wr), .charging(ch_wr));

    throw_charge #(.POWER_W(5), .TICK_DIV(4), .RAMP_MODE(RAMP_SAT),
                   .MIN_CHARGE_TICKS(3), .AUTO_RELEASE_TICKS(0)) dut_min (
        .clk60MHz(clk), .rst_n(rst_n), .left(left_min), .right(right), .turn(turn),
        .current_player(current_player), .end_throw(end_throw),
        .power(pw_min), .throw_flag(tf_min), .charging(ch_min));

    throw_charge #(.POWER_W(5), .TICK_DIV(4), .RAMP_MODE(RAMP_SAT),
                   .MIN_CHARGE_TICKS(1), .AUTO_RELEASE_TICKS(10)) dut_auto (
        .clk60MHz(clk), .rst_n(rst_n), .left(left_auto), .right(right), .turn(turn),
        .current_player(current_player), .end_throw(end_throw),
        .power(pw_auto), .throw_flag(tf_auto), .charging(ch_auto));

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_end_throw();
        end_throw = 1'b1;
        step(1);
        end_throw = 1'b0;
    endtask

    // After entering CHARGE on edge 1, power k appears after edge 1+4k.
    initial begin
        rst_n = 1'b0; right = 1'b0; turn = 1'b0; end_throw = 1'b0;
        current_player = PLAYER_1;
        left_sat = 1'b0; left_pp = 1'b0; left_wr = 1'b0; left_min = 1'b0; left_auto = 1'b0;
        step(2);
        check("rst_power",    32'(pw_sat), 32'd0);
        check("rst_flag",     32'(tf_sat), 32'd0);
        check("rst_charging", 32'(ch_sat), 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of a charge
        left_sat = 1'b1;
        step(29);
        check("t1_power7",    32'(pw_sat), 32'd7);
        check("t1_charging",  32'(ch_sat), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t1_async_power", 32'(pw_sat), 32'd0);
        check("t1_async_chg",   32'(ch_sat), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(1);
        check("t1_recharge_chg",   32'(ch_sat), 32'd1);
        check("t1_recharge_power", 32'(pw_sat), 32'd0);
        step(4);
        check("t1_recharge_p1",    32'(pw_sat), 32'd1);

        // SAT ramp, hold, release, end_throw
        step(120);
        check("t2_sat_max",  32'(pw_sat), 32'd31);
        step(35);
        check("t2_sat_hold", 32'(pw_sat), 32'd31);
        check("t2_no_flag",  32'(tf_sat), 32'd0);
        left_sat = 1'b0;
        step(1);
        check("t2_flag_up",  32'(tf_sat), 32'd1);
        check("t2_chg_down", 32'(ch_sat), 32'd0);
        check("t2_fire_pw",  32'(pw_sat), 32'd31);
        step(49);
        check("t2_flag_held", 32'(tf_sat), 32'd1);
        pulse_end_throw();
        check("t2_flag_down", 32'(tf_sat), 32'd0);
        step(1);
        check("t2_idle_flag",  32'(tf_sat), 32'd0);
        check("t2_idle_chg",   32'(ch_sat), 32'd0);
        check("t2_idle_power", 32'(pw_sat), 32'd31);

        // PINGPONG: 31 at tick 31, 27 after tick 35
        left_pp = 1'b1;
        step(125);
        check("t3_pp_31", 32'(pw_pp), 32'd31);
        step(16);
        check("t3_pp_27", 32'(pw_pp), 32'd27);
        left_pp = 1'b0;
        step(1);
        check("t3_pp_fire",  32'(tf_pp), 32'd1);
        check("t3_pp_latch", 32'(pw_pp), 32'd27);
        pulse_end_throw();
        check("t3_pp_done",  32'(tf_pp), 32'd0);

        // WRAP: 31, 0, 1 at ticks 31, 32, 33
        left_wr = 1'b1;
        step(125);
        check("t3_wr_31", 32'(pw_wr), 32'd31);
        step(4);
        check("t3_wr_0",  32'(pw_wr), 32'd0);
        step(4);
        check("t3_wr_1",  32'(pw_wr), 32'd1);
        left_wr = 1'b0;
        step(1);
        check("t3_wr_fire", 32'(tf_wr), 32'd1);
        pulse_end_throw();
        check("t3_wr_done", 32'(tf_wr), 32'd0);

        // Not my turn, then cancel with right at tick 5
        turn = 1'b1;
        left_sat = 1'b1;
        step(3);
        check("t4_notturn_chg",   32'(ch_sat), 32'd0);
        check("t4_notturn_power", 32'(pw_sat), 32'd31);
        turn = 1'b0;
        step(1);
        check("t4_start_chg", 32'(ch_sat), 32'd1);
        step(20);
        check("t4_power5", 32'(pw_sat), 32'd5);
        right = 1'b1;
        step(1);
        check("t4_cancel_chg",   32'(ch_sat), 32'd0);
        check("t4_cancel_power", 32'(pw_sat), 32'd0);
        check("t4_cancel_flag",  32'(tf_sat), 32'd0);
        right = 1'b0;
        left_sat = 1'b0;
        step(2);
        check("t4_no_throw", 32'(tf_sat), 32'd0);

        // Minimum charge reject, then release coincident with a tick
        left_min = 1'b1;
        step(9);
        check("t5_two_ticks", 32'(pw_min), 32'd2);
        left_min = 1'b0;
        step(1);
        check("t5_reject_flag",  32'(tf_min), 32'd0);
        check("t5_reject_chg",   32'(ch_min), 32'd0);
        check("t5_reject_power", 32'(pw_min), 32'd0);
        left_min = 1'b1;
        step(37);
        check("t5_power9", 32'(pw_min), 32'd9);
        step(3);
        left_min = 1'b0;
        step(1);
        check("t5_fire_flag",  32'(tf_min), 32'd1);
        check("t5_fire_power", 32'(pw_min), 32'd9);
        pulse_end_throw();
        check("t5_done", 32'(tf_min), 32'd0);

        // Auto-release after 10 ticks; end_throw in CHARGE ignored
        left_auto = 1'b1;
        step(20);
        pulse_end_throw();
        check("t6_end_ignored", 32'(ch_auto), 32'd1);
        step(20);
        check("t6_power10",   32'(pw_auto), 32'd10);
        check("t6_not_fired", 32'(tf_auto), 32'd0);
        step(1);
        check("t6_auto_fire",  32'(tf_auto), 32'd1);
        check("t6_auto_chg",   32'(ch_auto), 32'd0);
        check("t6_auto_power", 32'(pw_auto), 32'd10);
        step(5);
        check("t6_fire_hold",  32'(pw_auto), 32'd10);
        pulse_end_throw();
        check("t6_done", 32'(tf_auto), 32'd0);
        step(1);
        check("t6_recharge", 32'(ch_auto), 32'd1);
        check("t6_recharge_power", 32'(pw_auto), 32'd0);
        left_auto = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
